// File: rtl/bias_act_vec_top.sv
`default_nettype none
// ============================================================================
//  Module      : bias_act_vec_top (with lane adder fp_adder_driver_ba)
//  Description : C = act(X + B) over an MxN fp32 tile using LANES parallel
//                fp32 adders. Bias is per column or per row, with optional
//                ReLU, abort, element-valid flags and a busy-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================

// Lane adder: takes i_start while idle, raises o_busy for one cycle, then
// presents the fp32 sum on o_z with a one-cycle o_done pulse.
module fp_adder_driver_ba (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_z
);
    logic [31:0] r_a, r_b, r_z, w_sum;
    logic        r_busy, r_done;

    // fp32 add, round-to-nearest-even, 3 extra bits with sticky folded into bit 0
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic        sl, ss, rup, sticky;
        logic [23:0] ml, ms;
        logic [26:0] ext, shf;
        logic [27:0] s;
        logic [24:0] mr;
        logic [31:0] res;
        int          el, es, diff, e;
        res = 32'd0;
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) begin
            res = 32'h7FC0_0000;
        end else if (a[30:23] == 8'hFF) begin
            res = (b[30:23] == 8'hFF && a[31] != b[31]) ? 32'h7FC0_0000 : a;
        end else if (b[30:23] == 8'hFF) begin
            res = b;
        end else begin
            // Larger magnitude operand goes first so the result takes its sign
            if (a[30:0] >= b[30:0]) begin
                sl = a[31]; el = (a[30:23] == 0) ? 1 : int'(a[30:23]); ml = {(a[30:23] != 0), a[22:0]};
                ss = b[31]; es = (b[30:23] == 0) ? 1 : int'(b[30:23]); ms = {(b[30:23] != 0), b[22:0]};
            end else begin
                sl = b[31]; el = (b[30:23] == 0) ? 1 : int'(b[30:23]); ml = {(b[30:23] != 0), b[22:0]};
                ss = a[31]; es = (a[30:23] == 0) ? 1 : int'(a[30:23]); ms = {(a[30:23] != 0), a[22:0]};
            end
            diff = el - es;
            ext  = {ms, 3'b000};
            if (diff > 26) begin
                shf = 27'd0; sticky = |ms;
            end else begin
                shf = ext >> diff; sticky = ((shf << diff) != ext);
            end
            shf[0] = shf[0] | sticky;
            if (sl == ss) s = {1'b0, ml, 3'b000} + {1'b0, shf};
            else          s = {1'b0, ml, 3'b000} - {1'b0, shf};
            e = el;
            if (s[27]) begin
                s = {1'b0, s[27:2], s[1] | s[0]};
                e = e + 1;
            end
            for (int i = 0; i < 26; i++) begin
                if (!s[26] && s != 28'd0 && e > 1) begin
                    s = s << 1;
                    e = e - 1;
                end
            end
            rup = s[2] & (s[1] | s[0] | s[3]);
            mr  = {1'b0, s[26:3]} + {24'd0, rup};
            if (mr[24]) begin
                mr = mr >> 1;
                e  = e + 1;
            end
            if (s == 28'd0)  res = {sl & ss, 31'd0};
            else if (e >= 255) res = {sl, 8'hFF, 23'd0};
            else             res = {sl, (mr[23] ? 8'(e) : 8'd0), mr[22:0]};
        end
        return res;
    endfunction

    // Combinational sum of the latched operands
    always_comb w_sum = fp_add(r_a, r_b);

    // Accept a job while idle, deliver it one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0; r_b <= '0; r_z <= '0; r_busy <= 1'b0; r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                r_z    <= w_sum;
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end else if (i_start) begin
                r_a    <= i_a;
                r_b    <= i_b;
                r_busy <= 1'b1;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_z    = r_z;
endmodule

module bias_act_vec_top #(
    parameter int M      = 8,
    parameter int N      = 8,
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int BYTE_W = DATA_W / 8,
    parameter int ROW_W  = (M <= 1) ? 1 : $clog2(M),
    parameter int COL_W  = (N <= 1) ? 1 : $clog2(N),
    parameter int BD     = (M > N) ? M : N,
    parameter int BIDX_W = (BD <= 1) ? 1 : $clog2(BD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              bias_mode,
    input  logic              relu_en,
    output logic              busy,
    output logic              done,
    output logic              C_valid,
    output logic              aborted,
    output logic              wr_drop,
    output logic [31:0]       cyc_cnt,
    input  logic              cpu_x_we,
    input  logic [ROW_W-1:0]  cpu_x_row,
    input  logic [COL_W-1:0]  cpu_x_col,
    input  logic [DATA_W-1:0] cpu_x_wdata,
    input  logic [BYTE_W-1:0] cpu_x_wmask,
    input  logic              cpu_b_we,
    input  logic [BIDX_W-1:0] cpu_b_idx,
    input  logic [DATA_W-1:0] cpu_b_wdata,
    input  logic [BYTE_W-1:0] cpu_b_wmask,
    input  logic              c_rd_en,
    input  logic              c_rd_re,
    input  logic [ROW_W-1:0]  c_rd_row,
    input  logic [COL_W-1:0]  c_rd_col,
    output logic [DATA_W-1:0] c_rd_rdata,
    output logic              c_rd_rvalid,
    output logic              c_rd_elem_vld
);
    if (DATA_W != 32) begin : g_chk_width
        $error("bias_act_vec_top: DATA_W must be 32");
    end
    if (LANES < 1 || LANES > N || (N % LANES) != 0) begin : g_chk_lanes
        $error("bias_act_vec_top: LANES must divide N");
    end

    localparam logic [2:0]  S_IDLE = 3'd0, S_LOAD = 3'd1, S_LAUNCH = 3'd2, S_WAIT = 3'd3, S_WRITE = 3'd4;
    localparam logic [31:0] c_M_U = 32'(M);
    localparam logic [31:0] c_N_U = 32'(N);
    localparam logic [31:0] c_BD_U = 32'(BD);

    logic [2:0]        r_state;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic              r_mode, r_relu, r_done, r_aborted, r_wr_drop;
    logic [31:0]       r_cyc;
    logic [DATA_W-1:0] r_x [M][N];
    logic [DATA_W-1:0] r_c [M][N];
    logic              r_vld [M][N];
    logic [DATA_W-1:0] r_b [BD];
    logic [DATA_W-1:0] r_opa [LANES];
    logic [DATA_W-1:0] r_opb [LANES];
    logic [DATA_W-1:0] r_z   [LANES];
    logic [LANES-1:0]  r_acc, r_got;
    logic              r_rd_vld;
    logic [ROW_W-1:0]  r_rd_row;
    logic [COL_W-1:0]  r_rd_col;

    logic [LANES-1:0]  w_lane_start, w_lane_busy, w_lane_done, w_acc_nxt, w_got_nxt;
    logic [DATA_W-1:0] w_lane_z [LANES];
    logic [DATA_W-1:0] w_res    [LANES];
    logic [COL_W-1:0]  w_col    [LANES];
    logic [BIDX_W-1:0] w_bidx   [LANES];
    logic              w_start_acc, w_abort, w_last, w_write, w_rd_ok;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                                input logic [DATA_W-1:0] new_v,
                                                input logic [BYTE_W-1:0] mask);
        logic [DATA_W-1:0] v;
        v = old_v;
        for (int i = 0; i < BYTE_W; i++)
            if (mask[i]) v[i*8 +: 8] = new_v[i*8 +: 8];
        return v;
    endfunction

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_abort     = (r_state != S_IDLE) && abort;
    assign w_last      = (r_row == ROW_W'(M - 1)) && (r_col == COL_W'(N - LANES));
    assign w_write     = (r_state == S_WRITE) && !abort;
    assign w_acc_nxt   = r_acc | w_lane_busy;
    assign w_got_nxt   = r_got | w_lane_done;

    // Per-lane column/bias addressing and ReLU on the captured sums
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_col[k]        = r_col + COL_W'(k);
            w_bidx[k]       = r_mode ? BIDX_W'(r_row) : BIDX_W'(w_col[k]);
            w_res[k]        = (r_relu && r_z[k][DATA_W-1]) ? '0 : r_z[k];
            w_lane_start[k] = (r_state == S_LAUNCH) && !r_acc[k];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        fp_adder_driver_ba u_add (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_start (w_lane_start[k]),
            .i_a     (r_opa[k]),
            .i_b     (r_opb[k]),
            .o_busy  (w_lane_busy[k]),
            .o_done  (w_lane_done[k]),
            .o_z     (w_lane_z[k])
        );
    end

    // Sequencer: group walk over the tile, lane handshakes, abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE; r_row <= '0; r_col <= '0; r_mode <= 1'b0; r_relu <= 1'b0;
            r_done <= 1'b0; r_aborted <= 1'b0; r_acc <= '0; r_got <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_opa[k] <= '0; r_opb[k] <= '0; r_z[k] <= '0;
            end
        end else if (w_abort) begin
            r_state   <= S_IDLE;
            r_aborted <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_mode <= bias_mode; r_relu <= relu_en;
                    r_done <= 1'b0; r_aborted <= 1'b0;
                    r_row <= '0; r_col <= '0;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    for (int k = 0; k < LANES; k++) begin
                        r_opa[k] <= r_x[r_row][w_col[k]];
                        r_opb[k] <= r_b[w_bidx[k]];
                    end
                    r_acc <= '0; r_got <= '0;
                    r_state <= S_LAUNCH;
                end
                S_LAUNCH, S_WAIT: begin
                    // a fast lane may report done before all lanes are accepted
                    for (int k = 0; k < LANES; k++)
                        if (w_lane_done[k]) r_z[k] <= w_lane_z[k];
                    r_acc <= w_acc_nxt;
                    r_got <= w_got_nxt;
                    if (r_state == S_LAUNCH && &w_acc_nxt) r_state <= S_WAIT;
                    if (r_state == S_WAIT && &w_got_nxt)   r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (w_last) begin
                        r_done <= 1'b1; r_state <= S_IDLE;
                    end else begin
                        r_state <= S_LOAD;
                        if (r_col == COL_W'(N - LANES)) begin
                            r_col <= '0; r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + COL_W'(LANES);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // CPU writes to X and B, accepted only while idle and in range
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < N; c++) r_x[r][c] <= '0;
            for (int i = 0; i < BD; i++) r_b[i] <= '0;
        end else if (r_state == S_IDLE) begin
            if (cpu_x_we && 32'(cpu_x_row) < c_M_U && 32'(cpu_x_col) < c_N_U)
                r_x[cpu_x_row][cpu_x_col] <= merge(r_x[cpu_x_row][cpu_x_col], cpu_x_wdata, cpu_x_wmask);
            if (cpu_b_we && 32'(cpu_b_idx) < c_BD_U)
                r_b[cpu_b_idx] <= merge(r_b[cpu_b_idx], cpu_b_wdata, cpu_b_wmask);
        end
    end

    // Result tile and element-valid flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < N; c++) begin
                    r_c[r][c] <= '0; r_vld[r][c] <= 1'b0;
                end
        end else if (w_start_acc) begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < N; c++) r_vld[r][c] <= 1'b0;
        end else if (w_write) begin
            for (int k = 0; k < LANES; k++) begin
                r_c[r_row][w_col[k]]   <= w_res[k];
                r_vld[r_row][w_col[k]] <= 1'b1;
            end
        end
    end

    // Dropped-write flag and saturating busy-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_drop <= 1'b0; r_cyc <= '0;
        end else begin
            if (w_start_acc) r_wr_drop <= 1'b0;
            else if ((cpu_x_we || cpu_b_we) && r_state != S_IDLE) r_wr_drop <= 1'b1;
            if (w_start_acc) r_cyc <= '0;
            else if (r_state != S_IDLE && r_cyc != 32'hFFFF_FFFF) r_cyc <= r_cyc + 32'd1;
        end
    end

    // Read port: latch address on request, data follows combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld <= 1'b0; r_rd_row <= '0; r_rd_col <= '0;
        end else begin
            r_rd_vld <= c_rd_en & c_rd_re;
            if (c_rd_en & c_rd_re) begin
                r_rd_row <= c_rd_row; r_rd_col <= c_rd_col;
            end
        end
    end

    assign w_rd_ok       = (32'(r_rd_row) < c_M_U) && (32'(r_rd_col) < c_N_U);
    assign c_rd_rdata    = w_rd_ok ? r_c[r_rd_row][r_rd_col] : '0;
    assign c_rd_elem_vld = w_rd_ok & r_vld[r_rd_row][r_rd_col];
    assign c_rd_rvalid   = r_rd_vld;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign C_valid       = r_done;
    assign aborted       = r_aborted;
    assign wr_drop       = r_wr_drop;
    assign cyc_cnt       = r_cyc;
endmodule
`default_nettype wire

// File: tb/tb_bias_act_vec_top.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_bias_act_vec_top
//  Description : Self-checking bench for bias_act_vec_top (8x8 tile, 2 lanes)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bias_act_vec_top;
    localparam int M = 8, N = 8;
    localparam logic [31:0] F_ONE = 32'h3F80_0000, F_TWO = 32'h4000_0000, F_THREE = 32'h4040_0000;
    localparam logic [31:0] F_M3 = 32'hC040_0000, F_HALF = 32'h3F00_0000, F_M1 = 32'hBF80_0000;
    localparam logic [31:0] F_M2 = 32'hC000_0000, F_1P5 = 32'h3FC0_0000, F_SIX = 32'h40C0_0000;
    // 32 groups x (LOAD + 2 LAUNCH + WAIT + WRITE) busy cycles
    localparam logic [31:0] RUN_CYC = 32'd160;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 0, abort = 0, bias_mode = 0, relu_en = 0;
    logic busy, done, C_valid, aborted, wr_drop;
    logic [31:0] cyc_cnt;
    logic cpu_x_we = 0, cpu_b_we = 0;
    logic [2:0] cpu_x_row = 0, cpu_x_col = 0, cpu_b_idx = 0;
    logic [31:0] cpu_x_wdata = 0, cpu_b_wdata = 0;
    logic [3:0] cpu_x_wmask = 0, cpu_b_wmask = 0;
    logic c_rd_en = 0, c_rd_re = 0;
    logic [2:0] c_rd_row = 0, c_rd_col = 0;
    logic [31:0] c_rd_rdata;
    logic c_rd_rvalid, c_rd_elem_vld;

    always #5 clk = ~clk;

    bias_act_vec_top dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bias_mode(bias_mode),
        .relu_en(relu_en), .busy(busy), .done(done), .C_valid(C_valid), .aborted(aborted),
        .wr_drop(wr_drop), .cyc_cnt(cyc_cnt),
        .cpu_x_we(cpu_x_we), .cpu_x_row(cpu_x_row), .cpu_x_col(cpu_x_col),
        .cpu_x_wdata(cpu_x_wdata), .cpu_x_wmask(cpu_x_wmask),
        .cpu_b_we(cpu_b_we), .cpu_b_idx(cpu_b_idx), .cpu_b_wdata(cpu_b_wdata),
        .cpu_b_wmask(cpu_b_wmask),
        .c_rd_en(c_rd_en), .c_rd_re(c_rd_re), .c_rd_row(c_rd_row), .c_rd_col(c_rd_col),
        .c_rd_rdata(c_rd_rdata), .c_rd_rvalid(c_rd_rvalid), .c_rd_elem_vld(c_rd_elem_vld)
    );

    typedef struct {
        logic        mode;
        logic        relu;
        logic [31:0] b_even, b_odd;   // bias for even / odd index
        logic [31:0] c_even, c_odd;   // expected C for even / odd bias index
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic        vld;
    } exp_t;

    vec_t vecs[5];
    exp_t sb_q[$];
    int   n_tests = 0, n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr_x(input int r, input int c, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        cpu_x_we = 1; cpu_x_row = 3'(r); cpu_x_col = 3'(c); cpu_x_wdata = d; cpu_x_wmask = m;
        @(posedge clk); #1 cpu_x_we = 0;
    endtask

    task automatic wr_b(input int i, input logic [31:0] d);
        @(negedge clk);
        cpu_b_we = 1; cpu_b_idx = 3'(i); cpu_b_wdata = d; cpu_b_wmask = 4'hF;
        @(posedge clk); #1 cpu_b_we = 0;
    endtask

    // pop the oldest expectation and compare against the read port
    task automatic sb_pop(input string nm);
        exp_t e;
        check({nm, "_rvalid"}, 32'(c_rd_rvalid), 32'd1);
        if (sb_q.size() == 0) begin
            check({nm, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({nm, "_data"}, c_rd_rdata, e.data);
            check({nm, "_vld"}, 32'(c_rd_elem_vld), 32'(e.vld));
        end
    endtask

    task automatic rd(input string nm, input int r, input int c, input logic [31:0] d, input logic v);
        @(negedge clk);
        c_rd_en = 1; c_rd_re = 1; c_rd_row = 3'(r); c_rd_col = 3'(c);
        sb_q.push_back('{data: d, vld: v});
        @(posedge clk); #1 c_rd_en = 0; c_rd_re = 0;
        sb_pop(nm);
    endtask

    task automatic launch(input logic mode, input logic relu, input logic with_abort);
        @(negedge clk);
        start = 1; bias_mode = mode; relu_en = relu; abort = with_abort;
        @(posedge clk); #1 start = 0; abort = 0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string nm);
        int cyc = 0;
        while (!done && cyc < 1000) begin
            @(posedge clk); #1 cyc++;
        end
        check({nm, "_done"}, 32'(done), 32'd1);
        check({nm, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{mode: 0, relu: 0, b_even: F_TWO,  b_odd: F_TWO,  c_even: F_THREE, c_odd: F_THREE};
        vecs[1] = '{mode: 1, relu: 0, b_even: F_M3,   b_odd: F_HALF, c_even: F_M2,    c_odd: F_1P5};
        vecs[2] = '{mode: 1, relu: 1, b_even: F_M3,   b_odd: F_HALF, c_even: 32'h0,   c_odd: F_1P5};
        vecs[3] = '{mode: 0, relu: 1, b_even: F_M3,   b_odd: F_HALF, c_even: 32'h0,   c_odd: F_1P5};
        vecs[4] = '{mode: 0, relu: 0, b_even: F_HALF, b_odd: F_M1,   c_even: F_1P5,   c_odd: 32'h0};

        // reset state
        #23;
        check("rst_busy", 32'(busy), 0);       check("rst_done", 32'(done), 0);
        check("rst_cvalid", 32'(C_valid), 0); check("rst_aborted", 32'(aborted), 0);
        check("rst_wr_drop", 32'(wr_drop), 0); check("rst_cyc", cyc_cnt, 0);
        check("rst_rdata", c_rd_rdata, 0);     check("rst_rvalid", 32'(c_rd_rvalid), 0);
        check("rst_elem_vld", 32'(c_rd_elem_vld), 0);
        @(negedge clk); rst_n = 1;

        // enable without re is not a read
        @(negedge clk); c_rd_en = 1; c_rd_re = 0;
        @(posedge clk); #1 c_rd_en = 0;
        check("rd_en_only_rvalid", 32'(c_rd_rvalid), 0);

        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++) wr_x(r, c, F_ONE, 4'hF);

        // table-driven runs
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 8; i++) wr_b(i, (i % 2 == 0) ? vecs[v].b_even : vecs[v].b_odd);
            launch(vecs[v].mode, vecs[v].relu, 1'b0);
            wait_done($sformatf("vec%0d", v));
            check($sformatf("vec%0d_cvalid", v), 32'(C_valid), 1);
            if (v == 0) check("run_cyc_cnt", cyc_cnt, RUN_CYC);
            for (int r = 0; r < M; r++)
                for (int c = 0; c < N; c++)
                    rd($sformatf("vec%0d_c%0d_%0d", v, r, c), r, c,
                       (((vecs[v].mode ? r : c) % 2) == 0) ? vecs[v].c_even : vecs[v].c_odd, 1'b1);
        end

        // byte-masked X writes: top byte only gives 4.0, empty mask changes nothing
        for (int i = 0; i < 8; i++) wr_b(i, F_TWO);
        wr_x(0, 0, 32'h40FF_FFFF, 4'b1000);
        wr_x(0, 1, 32'hDEAD_BEEF, 4'b0000);
        launch(1'b0, 1'b0, 1'b0);
        wait_done("mask");
        rd("mask_c00", 0, 0, F_SIX, 1'b1);
        rd("mask_c01", 0, 1, F_THREE, 1'b1);
        wr_x(0, 0, F_ONE, 4'hF);

        // write while busy is dropped; start while busy ignored; back-to-back reads
        launch(1'b0, 1'b0, 1'b0);
        wr_x(0, 0, 32'hDEAD_BEEF, 4'hF);
        check("wr_drop_set", 32'(wr_drop), 1);
        @(negedge clk); start = 1; @(negedge clk); start = 0;
        @(negedge clk);
        c_rd_en = 1; c_rd_re = 1; c_rd_row = 3; c_rd_col = 3;
        sb_q.push_back('{data: F_THREE, vld: 1'b0});
        @(posedge clk); #1 sb_pop("b2b_0");
        @(negedge clk); c_rd_row = 5; c_rd_col = 4;
        sb_q.push_back('{data: F_THREE, vld: 1'b0});
        @(posedge clk); #1 sb_pop("b2b_1");
        @(negedge clk); c_rd_en = 0; c_rd_re = 0;
        @(posedge clk); #1 check("b2b_rvalid_low", 32'(c_rd_rvalid), 0);
        wait_done("drop");
        check("busy_start_cyc", cyc_cnt, RUN_CYC);
        check("wr_drop_held", 32'(wr_drop), 1);
        launch(1'b0, 1'b0, 1'b0);
        check("wr_drop_cleared", 32'(wr_drop), 0);
        wait_done("drop2");
        rd("drop_x_unchanged", 0, 0, F_THREE, 1'b1);

        // abort once group 2 has written (0,4),(0,5)
        launch(1'b0, 1'b0, 1'b0);
        @(negedge clk); c_rd_en = 1; c_rd_re = 1; c_rd_row = 0; c_rd_col = 5;
        begin
            int cyc = 0;
            @(posedge clk); #1;
            while (!c_rd_elem_vld && cyc < 500) begin
                @(posedge clk); #1 cyc++;
            end
            check("abort_wait_g2", 32'(c_rd_elem_vld), 1);
        end
        @(negedge clk); c_rd_en = 0; c_rd_re = 0; abort = 1;
        @(posedge clk); #1 abort = 0;
        check("abort_busy", 32'(busy), 0);
        check("abort_aborted", 32'(aborted), 1);
        check("abort_done", 32'(done), 0);
        check("abort_cvalid", 32'(C_valid), 0);
        for (int c = 0; c < 6; c++) rd($sformatf("abort_kept_%0d", c), 0, c, F_THREE, 1'b1);
        rd("abort_c06_invalid", 0, 6, F_THREE, 1'b0);

        // start together with abort in IDLE: start wins
        launch(1'b0, 1'b0, 1'b1);
        check("restart_aborted_clr", 32'(aborted), 0);
        wait_done("restart");
        check("restart_aborted", 32'(aborted), 0);
        rd("restart_c77", 7, 7, F_THREE, 1'b1);

        // asynchronous reset in the middle of a run
        launch(1'b0, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_cyc", cyc_cnt, 0);
        @(negedge clk); rst_n = 1;
        rd("arst_c00", 0, 0, 32'h0, 1'b0);
        rd("arst_c34", 3, 4, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
